task_issue_queue: RTL

//  In-order, 2-wide FIFO between instruction decode and the issue/dispatch logic.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/task_issue_queue_if.sv | 31 +++
 rtl/task_issue_queue_ram.sv | 28 ++
 rtl/task_issue_queue.sv | 74 +++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types: shared decode/issue types and system-level queue depth.
package cpu_types;
    typedef enum logic [2:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LD, OP_ST, OP_BR
    } opcode_t;
    typedef struct packed {
        opcode_t     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] seq;
    } task_t;
    localparam int IQ_DEPTH = 8;
endpackage

// File: rtl/task_issue_queue_if.sv
// task_issue_queue_if: decode-side enqueue and dispatch-side dequeue signals of the issue queue.
interface task_issue_queue_if
    import cpu_types::*;
#(
    parameter int DEPTH = IQ_DEPTH
);
    localparam int PTR_W = $clog2(DEPTH);
    logic             flush;
    logic             in_valid_0;
    logic             in_valid_1;
    task_t            task_in_0;
    task_t            task_in_1;
    logic             in_ready;
    logic             out_valid_0;
    logic             out_valid_1;
    task_t            task_out_0;
    task_t            task_out_1;
    logic             deq_0;
    logic             deq_1;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    modport master (
        output flush, in_valid_0, in_valid_1, task_in_0, task_in_1, deq_0, deq_1,
        input  in_ready, out_valid_0, out_valid_1, task_out_0, task_out_1, count, empty, full
    );
    modport slave (
        input  flush, in_valid_0, in_valid_1, task_in_0, task_in_1, deq_0, deq_1,
        output in_ready, out_valid_0, out_valid_1, task_out_0, task_out_1, count, empty, full
    );
endinterface

// File: rtl/task_issue_queue_ram.sv
// task_ram_2w2r: DEPTH x task_t storage, two synchronous write ports, two asynchronous read ports.
module task_ram_2w2r
    import cpu_types::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_0,
    input  logic [PTR_W-1:0] wa_0,
    input  task_t            wd_0,
    input  logic             we_1,
    input  logic [PTR_W-1:0] wa_1,
    input  task_t            wd_1,
    input  logic [PTR_W-1:0] ra_0,
    output task_t            rd_0,
    input  logic [PTR_W-1:0] ra_1,
    output task_t            rd_1
);
    task_t mem [DEPTH];
    // Write addresses are always distinct (tail and tail+1), so port order does not matter.
    always_ff @(posedge clk) begin
        if (we_0) mem[wa_0] <= wd_0;
        if (we_1) mem[wa_1] <= wd_1;
    end
    assign rd_0 = mem[ra_0];
    assign rd_1 = mem[ra_1];
endmodule

// File: rtl/task_issue_queue.sv
// task_issue_queue: in-order 2-wide issue FIFO; enqueues up to two decoded tasks and
// presents the two oldest to the dispatcher, which pops 0, 1 or 2 per cycle.
module task_issue_queue
    import cpu_types::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst_n,
    task_issue_queue_if.slave q
);
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [1:0]       n_enq;
    logic [1:0]       n_deq;
    logic             we_0;
    logic             we_1;
    logic             take_0;
    logic             take_1;
    task_t            rd_0;
    task_t            rd_1;

    // Occupancy flags come from the registered count only, so in_ready has no path from inputs.
    assign q.count       = count;
    assign q.empty       = count == '0;
    assign q.full        = count == (PTR_W+1)'(DEPTH);
    assign q.in_ready    = count <= (PTR_W+1)'(DEPTH - 2);
    assign q.out_valid_0 = count != '0;
    assign q.out_valid_1 = count >= (PTR_W+1)'(2);
    assign q.task_out_0  = q.out_valid_0 ? rd_0 : '0;
    assign q.task_out_1  = q.out_valid_1 ? rd_1 : '0;

    always_comb begin
        we_0   = q.in_ready & ~q.flush & (q.in_valid_0 | q.in_valid_1);
        we_1   = q.in_ready & ~q.flush & q.in_valid_0 & q.in_valid_1;
        take_0 = q.deq_0 & q.out_valid_0;
        take_1 = take_0 & q.deq_1 & q.out_valid_1;
        n_enq  = {1'b0, we_0} + {1'b0, we_1};
        n_deq  = {1'b0, take_0} + {1'b0, take_1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(n_deq);
            tail  <= tail + PTR_W'(n_enq);
            count <= count + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
        end
    end

    // A lone in_valid_1 lands at tail so no hole is left behind.
    task_ram_2w2r #(.DEPTH(DEPTH)) u_ram (
        .clk  (clk),
        .we_0 (we_0),
        .wa_0 (tail),
        .wd_0 (q.in_valid_0 ? q.task_in_0 : q.task_in_1),
        .we_1 (we_1),
        .wa_1 (tail + PTR_W'(1)),
        .wd_1 (q.task_in_1),
        .ra_0 (head),
        .rd_0 (rd_0),
        .ra_1 (head + PTR_W'(1)),
        .rd_1 (rd_1)
    );
endmodule
